// File: rtl/fetch_aligner.sv
// Realigns a word-aligned fetch stream into 16/32-bit instructions for the decoder.
// Define FETCH_ALIGNER_RVC_EN for halfword alignment; undefined gives a one-word pass-through.
`timescale 1ns/1ps
module fetch_aligner #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] fetch_data,
    input  logic        fetch_valid,
    output logic        fetch_ready,
    input  logic        flush,
    input  logic [31:0] redirect_pc,
    output logic [31:0] ins,
    output logic [31:0] ins_pc,
    output logic        ins_valid,
    input  logic        ins_ready
);
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [1:0]  count_q;
    logic [1:0]  count_d;
    logic        push;
    logic        pop;

    assign ins_pc = pc_q;
    assign push   = fetch_valid && fetch_ready;
    assign pop    = ins_valid && ins_ready;

`ifdef FETCH_ALIGNER_RVC_EN
    localparam int unsigned HW_W  = 16;
    localparam int unsigned DEPTH = 3;

    logic [HW_W-1:0] hw_q [DEPTH];
    logic [HW_W-1:0] hw_d [DEPTH];
    logic            discard_q;
    logic            compressed;
    logic [1:0]      pop_n;
    logic [1:0]      push_n;
    logic [1:0]      rem;
    logic [HW_W-1:0] first_hw;

    assign compressed  = hw_q[0][1:0] != 2'b11;
    assign fetch_ready = (count_q <= 2'd1) && !rst;
    assign ins_valid   = ((count_q >= 2'd1) && compressed) || (count_q >= 2'd2);

    always_comb begin
        ins = '0;
        if (ins_valid) begin
            ins = compressed ? {16'h0, hw_q[0]} : {hw_q[1], hw_q[0]};
        end
    end

    assign pop_n    = pop ? (compressed ? 2'd1 : 2'd2) : 2'd0;
    assign push_n   = push ? (discard_q ? 2'd1 : 2'd2) : 2'd0;
    assign rem      = count_q - pop_n;
    assign first_hw = discard_q ? fetch_data[31:16] : fetch_data[15:0];

    // Shift out popped halfwords, then append the accepted word behind the survivors.
    always_comb begin
        case (pop_n)
            2'd1:    hw_d = '{hw_q[1], hw_q[2], hw_q[2]};
            2'd2:    hw_d = '{hw_q[2], hw_q[2], hw_q[2]};
            default: hw_d = hw_q;
        endcase
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (push && 2'(i) == rem) begin
                hw_d[i] = first_hw;
            end else if (push && !discard_q && 2'(i) == rem + 2'd1) begin
                hw_d[i] = fetch_data[31:16];
            end
        end
    end

    always_comb begin
        count_d = rem + push_n;
        pc_d    = pop ? pc_q + (compressed ? 32'd2 : 32'd4) : pc_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= 2'd0;
            pc_q      <= RESET_PC;
            discard_q <= 1'b0;
        end else if (flush) begin
            count_q   <= 2'd0;
            pc_q      <= {redirect_pc[31:1], 1'b0};
            discard_q <= redirect_pc[1];
        end else begin
            count_q   <= count_d;
            pc_q      <= pc_d;
            discard_q <= discard_q && !push;
        end
    end

    // Halfword storage needs no reset: count gates every use.
    always_ff @(posedge clk) begin
        hw_q <= hw_d;
    end
`else
    logic [31:0] word_q;
    logic        unused_redirect;

    assign unused_redirect = ^redirect_pc[1:0];
    assign fetch_ready     = (count_q == 2'd0) && !rst;
    assign ins_valid       = count_q != 2'd0;
    assign ins             = ins_valid ? word_q : '0;

    always_comb begin
        count_d = count_q;
        if (push) begin
            count_d = 2'd1;
        end else if (pop) begin
            count_d = 2'd0;
        end
        pc_d = pop ? pc_q + 32'd4 : pc_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 2'd0;
            pc_q    <= RESET_PC;
        end else if (flush) begin
            count_q <= 2'd0;
            pc_q    <= {redirect_pc[31:2], 2'b00};
        end else begin
            count_q <= count_d;
            pc_q    <= pc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            word_q <= fetch_data;
        end
    end
`endif
endmodule
